// File: rtl/stretch_mc.sv
// stretch_mc: multi-channel pulse delay and stretcher.
// Each channel sees a rising edge on in[i], waits DELAY_TICKS+1 cycles, then
// drives out[i] high for a latched, clamped number of cycles. busy[i] and
// missed[i] report channel occupancy and discarded triggers.
module stretch_mc #(
  parameter int CHANNELS         = 4,
  parameter int DELAY_TICKS      = 100,
  parameter int MAX_LENGTH_TICKS = 100,
  parameter int RETRIGGER        = 0,
  localparam int LW              = $clog2(MAX_LENGTH_TICKS + 1),
  localparam int DW_RAW          = $clog2(DELAY_TICKS + 1),
  localparam int DW              = (DW_RAW < 1) ? 1 : DW_RAW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    in,
  input  logic [CHANNELS*LW-1:0] strch,
  output logic [CHANNELS-1:0]    out,
  output logic [CHANNELS-1:0]    busy,
  output logic [CHANNELS-1:0]    missed
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  logic [CHANNELS-1:0] in_q;
  logic [CHANNELS-1:0] trig;

  // Previous trigger level, so a rising edge is a 1 seen against a registered 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q <= '0;
    end else begin
      in_q <= in;
    end
  end

  assign trig = in & ~in_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : gCh
    state_e        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] reqLen;
    logic          drop_d, drop_q;
    logic          out_q, busy_q, missed_q;

    // The delay phase always lasts DELAY_TICKS+1 state cycles (at least one),
    // which gives the trigger-to-out latency of DELAY_TICKS+1 edges; with
    // DELAY_TICKS=0 the DELAY state is therefore a single pass-through cycle.
    // In ACTIVE, len_q counts the remaining cycles after the current one.
    assign reqLen = (strch[c*LW +: LW] > LW'(MAX_LENGTH_TICKS)) ?
                    LW'(MAX_LENGTH_TICKS) : strch[c*LW +: LW];

    // Next-state logic: accept triggers in IDLE, count down delay and length, flag drops.
    always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      len_d   = len_q;
      drop_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (trig[c]) begin
            state_d = DELAY;
            dly_d   = DW'(DELAY_TICKS);
            len_d   = reqLen;
          end
        end
        DELAY: begin
          drop_d = trig[c];
          if (dly_q == '0) begin
            if (len_q == '0) begin
              state_d = IDLE;
            end else begin
              state_d = ACTIVE;
              len_d   = len_q - LW'(1);
            end
          end else begin
            dly_d = dly_q - DW'(1);
          end
        end
        ACTIVE: begin
          if (trig[c] && (RETRIGGER != 0)) begin
            len_d = reqLen;
          end else begin
            drop_d = trig[c];
            if (len_q == '0) begin
              state_d = IDLE;
            end else begin
              len_d = len_q - LW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          dly_d   = '0;
          len_d   = '0;
        end
      endcase
    end

    // State, counters and registered outputs; busy and missed trail by one edge.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= IDLE;
        dly_q    <= '0;
        len_q    <= '0;
        drop_q   <= 1'b0;
        out_q    <= 1'b0;
        busy_q   <= 1'b0;
        missed_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        dly_q    <= dly_d;
        len_q    <= len_d;
        drop_q   <= drop_d;
        out_q    <= (state_d == ACTIVE);
        busy_q   <= (state_q != IDLE);
        missed_q <= drop_q;
      end
    end

    assign out[c]    = out_q;
    assign busy[c]   = busy_q;
    assign missed[c] = missed_q;
  end

endmodule

// File: doc/stretch_mc.md
STRETCH_MC -- requirements
Module: stretch_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent pulse channels (>=1).
REQ-002 SHALL have parameter DELAY_TICKS, default 100, clock cycles from trigger to out assertion (>=0).
REQ-003 SHALL have parameter MAX_LENGTH_TICKS, default 100, upper clamp on pulse length in cycles (>=1).
REQ-004 SHALL have parameter RETRIGGER, default 0; 1 = rising edge during active pulse reloads length, 0 = ignored.
REQ-005 SHALL define LW = $clog2(MAX_LENGTH_TICKS+1) and DW = $clog2(DELAY_TICKS+1), DW forced to >=1.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-008 SHALL have port in  input  CHANNELS  per-channel trigger level, synchronous to clk.
REQ-009 SHALL have port strch  input  CHANNELS*LW  per-channel requested length; channel i at bits [i*LW +: LW].
REQ-010 SHALL have port out  output  CHANNELS  per-channel stretched, delayed pulse, registered.
REQ-011 SHALL have port busy  output  CHANNELS  channel in DELAY or ACTIVE state, registered.
REQ-012 SHALL have port missed  output  CHANNELS  one-cycle flag: a trigger was discarded, registered.

Function
REQ-013 SHALL register in into in_q per channel; trigger at edge n = in[i]=1 and in_q[i]=0 sampled at edge n.
REQ-014 SHALL implement per channel an FSM with states IDLE, DELAY, ACTIVE; channels fully independent.
REQ-015 SHALL latch L = min(strch[i], MAX_LENGTH_TICKS) at the trigger edge; later strch changes do not affect that pulse.
REQ-016 SHALL on trigger in IDLE at edge n: assert out[i] at edge n+DELAY_TICKS+1 and deassert at edge n+DELAY_TICKS+1+L (exactly L cycles high).
REQ-017 SHALL with DELAY_TICKS=0 go IDLE->ACTIVE directly; out rises at edge n+1.
REQ-018 SHALL with L=0 produce no out pulse; channel returns to IDLE at edge n+DELAY_TICKS+1.
REQ-019 SHALL hold busy[i]=1 from edge n+1 through the edge where out deasserts (or DELAY ends for L=0); busy=0 in IDLE.
REQ-020 SHALL ignore triggers in DELAY state and pulse missed[i]=1 for one cycle at edge m+1 for trigger edge m.
REQ-021 SHALL with RETRIGGER=1, on trigger in ACTIVE at edge m, latch new L' and keep out high continuously, deasserting at edge m+1+L'; no missed pulse; L'=0 deasserts at m+1.
REQ-022 SHALL with RETRIGGER=0 ignore triggers in ACTIVE, leave pulse timing unchanged, and pulse missed[i] at m+1.
REQ-023 SHALL accept a trigger on the same edge the channel returns to IDLE only from the following edge; a trigger coinciding with the final ACTIVE/DELAY edge counts as missed (RETRIGGER=0) or reload (RETRIGGER=1, ACTIVE only).
REQ-024 SHALL use saturating-free down-counters of widths DW and LW; no counter wraps in any state.

Reset
REQ-025 SHALL on rst=0 immediately (asynchronously) force out=0, busy=0, missed=0, in_q=0, all FSMs IDLE, counters 0.
REQ-026 SHALL abort any pulse in progress on reset mid-operation; no residual pulse after rst returns to 1.
REQ-027 SHALL treat in[i]=1 on the first edge after reset release as a trigger (in_q reset value 0).

Verification (CHANNELS=2, DELAY_TICKS=4, MAX_LENGTH_TICKS=8)
REQ-028 SHALL check reset: rst=0 during active pulse -> out, busy, missed = 0 within same cycle; no pulse after release.
REQ-029 SHALL check basic: ch0 strch=3, in rises at edge 10 -> out[0] high edges 15..17, low at 18; busy[0] high 11..18; ch1 stays 0.
REQ-030 SHALL check clamp and zero: strch=12 -> out high 15..22 (8 cycles); strch=0 -> out never high, busy high 11..15.
REQ-031 SHALL check retrigger: strch=3, rises at edges 10 and 16; RETRIGGER=1 -> out high 15..19, low at 20; RETRIGGER=0 -> low at 18, missed[0] high at 17 only.
REQ-032 SHALL check drop in DELAY: rises at edges 10 and 12 -> single pulse 15..17, missed[0] high at edge 13 only.
REQ-033 SHALL check independence: ch0 and ch1 triggered at edges 10 and 11 with strch 2 and 5 -> out[0] high 15..16, out[1] high 16..20.
